// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: arbitrates ALU (A) and load (B) writebacks onto one register-file write port.
// Round-robin by default; define REGARB_FIXED_PRIO_EN to give port A fixed priority.
module regfile_write_arbiter #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_stall,
  input  logic                   i_a_valid,
  output logic                   o_a_ready,
  input  logic [ADDR_W-1:0]      i_a_rd,
  input  logic [DATA_W-1:0]      i_a_data,
  input  logic                   i_b_valid,
  output logic                   o_b_ready,
  input  logic [ADDR_W-1:0]      i_b_rd,
  input  logic [DATA_W-1:0]      i_b_data,
  output logic                   o_reg_write,
  output logic [ADDR_W-1:0]      o_rd,
  output logic [DATA_W-1:0]      o_write_data,
  output logic [(1<<ADDR_W)-1:0] o_pending,
  output logic                   o_last_grant,
  output logic [CNT_W-1:0]       o_conflict_count
);
  localparam int NREG = 1 << ADDR_W;
  logic              r_reg_write;
  logic [ADDR_W-1:0] r_rd;
  logic [DATA_W-1:0] r_write_data;
  logic              r_last_grant;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_grant_a;
  logic              w_grant_b;
  logic              w_conflict;
  assign w_conflict = i_a_valid & i_b_valid & ~i_stall;
`ifdef REGARB_FIXED_PRIO_EN
  assign w_grant_a = i_a_valid & ~i_stall;
  assign w_grant_b = i_b_valid & ~i_stall & ~i_a_valid;
`else
  // On a conflict the port that did not win last time goes first.
  assign w_grant_a = i_a_valid & ~i_stall & (~i_b_valid | r_last_grant);
  assign w_grant_b = i_b_valid & ~i_stall & (~i_a_valid | ~r_last_grant);
`endif
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_reg_write  <= 1'b0;
      r_rd         <= '0;
      r_write_data <= '0;
      r_last_grant <= 1'b1;
      r_cnt        <= '0;
    end else begin
      r_reg_write <= w_grant_a | w_grant_b;
      if (w_grant_a | w_grant_b) begin
        r_rd         <= w_grant_a ? i_a_rd : i_b_rd;
        r_write_data <= w_grant_a ? i_a_data : i_b_data;
        r_last_grant <= w_grant_b;
      end
      if (w_conflict && r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
    end
  assign o_a_ready        = w_grant_a;
  assign o_b_ready        = w_grant_b;
  assign o_reg_write      = r_reg_write;
  assign o_rd             = r_rd;
  assign o_write_data     = r_write_data;
  assign o_pending        = r_reg_write ? {{(NREG-1){1'b0}}, 1'b1} << r_rd : '0;
  assign o_last_grant     = r_last_grant;
  assign o_conflict_count = r_cnt;
endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the register file's single write port between two writeback requesters: port A (ALU result) and port B (memory load). Each requester uses a valid/ready handshake. The arbiter grants at most one request per cycle, round-robin by default, and registers the winner onto the register file's RegWrite/RD/WriteData inputs. It also exports a per-register pending mask and a saturating conflict counter for the control unit and for debug.

## Interface
Parameters:
- ADDR_W, 2, register address width; the register count is 2^ADDR_W.
- DATA_W, 16, write data width.
- CNT_W, 8, conflict counter width.

Ports:
- Clock  in  1  rising-edge clock.
- Reset_n  in  1  asynchronous, active-low reset.
- Stall  in  1  when high, no new grants are made.
- A_Valid  in  1  port A request.
- A_Ready  out  1  port A accepted this cycle (combinational).
- A_Rd  in  ADDR_W  port A destination register.
- A_Data  in  DATA_W  port A write data.
- B_Valid, B_Ready, B_Rd, B_Data: same as the port A signals, for port B.
- RegWrite  out  1  write enable to the register file.
- RD  out  ADDR_W  write address to the register file.
- WriteData  out  DATA_W  write data to the register file.
- Pending  out  2^ADDR_W  one-hot mask of the register being written at the next edge.
- LastGrant  out  1  0 = A was granted last, 1 = B was granted last.
- ConflictCount  out  CNT_W  saturating count of cycles with both requests valid and no stall.

## Operation
- One clock, Clock. Reset is asynchronous and active-low on Reset_n.

Handshake:
- A transfer occurs on a rising edge where X_Valid && X_Ready.
- A requester must hold Valid, Rd and Data stable until it is accepted.
- Ready must never be asserted when Valid is low.

Arbitration (combinational, per cycle):
- Stall high: A_Ready = B_Ready = 0.
- Only one port valid: that port is granted.
- Both ports valid: the port not equal to LastGrant wins. LastGrant=1 grants A; LastGrant=0 grants B.

Output stage (registered), on each rising edge:
- RegWrite <= (grant A or grant B).
- RD/WriteData <= the granted port's Rd/Data. They hold their old values when there is no grant.
- LastGrant updates only on a grant.

Pending and counter:
- Pending = RegWrite ? onehot(RD) : 0.
- ConflictCount increments when A_Valid && B_Valid && !Stall.
- ConflictCount saturates at 2^CNT_W-1 and does not wrap.

No internal buffering:
- The output register is drained by the register file every cycle, so the block always accepts a new request unless Stall is high.

## Timing
Reset values:
- RegWrite=0, RD=0, WriteData=0, Pending=0, LastGrant=1 (A wins the first conflict), ConflictCount=0.

Latency:
- A request accepted at edge k drives RegWrite=1 between edges k and k+1.
- The register file captures the write at edge k+1, and its read ports show the new value after edge k+1.
- Sustained throughput is one write per cycle.

Stall:
- Stall does not cancel a write already in the output register; that write completes at the next edge.
- RegWrite drops to 0 one cycle after Stall rises.

Same destination:
- Back-to-back writes from A and B to the same register complete in grant order. The later grant's data is the final value.

Reset mid-operation:
- Asserting Reset_n low clears RegWrite immediately, without waiting for a clock edge.
- A write accepted but not yet captured by the register file is dropped.
- Requesters must re-present their requests after reset.

## Configuration
- REGARB_FIXED_PRIO_EN defined:
  - Port A always wins a conflict.
  - LastGrant is still updated for observation but is ignored by the arbiter.
  - B can starve under continuous A traffic.
- REGARB_FIXED_PRIO_EN undefined (default): round-robin as described in Operation.

## Test plan
1. Reset, then A_Valid=1, A_Rd=2, A_Data=16'h1234 for 1 cycle -> A_Ready=1; the next cycle shows RegWrite=1, RD=2, WriteData=16'h1234, Pending=4'b0100; the following cycle shows RegWrite=0.
2. A and B both valid for 4 cycles (A_Rd=1/16'hAAAA, B_Rd=3/16'hBBBB; each port is re-presented after acceptance) -> grants A,B,A,B; ConflictCount=4; LastGrant alternates 0,1,0,1.
3. Same as test 2 with REGARB_FIXED_PRIO_EN defined -> A granted all 4 cycles, B_Ready stays 0, ConflictCount=4.
4. A accepted at edge k with Stall=1 from edge k onward -> the write to RD completes (RegWrite=1 for one cycle), then RegWrite=0; A_Ready and B_Ready stay 0 while Stall is high.
5. A accepted with A_Rd=0/16'h0001, then B accepted with B_Rd=0/16'h0002 next cycle -> register 0 reads 16'h0002 after the second write edge.
6. Reset_n pulsed low while RegWrite=1 -> RegWrite, Pending and ConflictCount are 0 immediately (asynchronous), and LastGrant=1; with CNT_W=2 and 5 conflict cycles, ConflictCount saturates at 3.
